branch_predictor_tournament_p: RTL
==================================

Name: branch_predictor_tournament_p

Overview:
Parametrised tournament branch predictor for the mips_core decode stage, driven by branch_controller. It pairs a gshare table with a per-PC local counter table and a chooser table, all with configurable sizes and counter widths. It adds three behaviours: a hardware table-initialisation sweep after reset, speculative global-history repair on mispredict, and saturating branch/mispredict statistics counters.

Parameters:
ADDR_WIDTH, 32, PC width
PC_SHIFT, 2, low PC bits dropped before indexing (word alignment)
GHR_BITS, 8, global history length; gshare and chooser tables have 2^GHR_BITS entries
LOCAL_IDX_BITS, 6, local table has 2^LOCAL_IDX_BITS entries
CTR_BITS, 2, width of gshare and local saturating counters (>=2)
CHOOSER_BITS, 2, width of chooser saturating counters (>=2)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
o_ready  out  1  1 = tables initialised, predictor live
i_req_valid  in  1  conditional branch in decode needs a prediction
i_req_pc  in  ADDR_WIDTH  decode PC
o_req_prediction  out  1  final prediction (1 = TAKEN)
o_req_pred_global  out  1  gshare component prediction
o_req_pred_local  out  1  local component prediction
o_req_ghistory  out  GHR_BITS  GHR value used for this prediction
i_fb_valid  in  1  resolved branch from EX
i_fb_pc  in  ADDR_WIDTH  PC of resolved branch
i_fb_ghistory  in  GHR_BITS  GHR snapshot carried with the branch
i_fb_prediction  in  1  final prediction that was made
i_fb_pred_global  in  1  gshare prediction that was made
i_fb_pred_local  in  1  local prediction that was made
i_fb_outcome  in  1  actual outcome
o_stat_branches  out  STAT_WIDTH  resolved-branch count
o_stat_mispredicts  out  STAT_WIDTH  mispredict count

Behaviour:
- FSM states INIT and RUN. rst=1 -> INIT, sweep index=0, GHR=0, both stats=0, o_ready=0. Reset mid-sweep or mid-run restarts the full sweep.
- INIT: each cycle writes sweep index into all three tables, clipping the index to each table's width.
  - gshare and local counters are written with 2^(CTR_BITS-1)-1 (weak not-taken).
  - Chooser counters are written with 2^(CHOOSER_BITS-1)-1 (weak global).
  - The sweep runs N = 2^max(GHR_BITS,LOCAL_IDX_BITS) cycles. After writing index N-1, the next cycle is RUN with o_ready=1.
  - In INIT, req/fb are ignored, all prediction outputs are 0, and o_req_ghistory=0.
- Indexing:
  - gidx = i_req_pc[PC_SHIFT +: GHR_BITS] ^ GHR
  - lidx = i_req_pc[PC_SHIFT +: LOCAL_IDX_BITS]
  - Feedback indices are computed the same way from i_fb_pc and i_fb_ghistory.
- Prediction is combinational, zero latency, and independent of i_req_valid.
  - Component prediction = counter MSB.
  - Chooser MSB=0 selects global; MSB=1 selects local.
- Feedback updates in RUN when i_fb_valid:
  - gshare[fb gidx] and local[fb lidx] saturate toward the outcome (+1 if taken, -1 if not), clamping at 0 and 2^CTR_BITS-1.
  - The chooser updates only when i_fb_pred_global != i_fb_pred_local: -1 (toward global) if the global prediction was correct, else +1, saturating.
- GHR, in priority order:
  - Mispredict (i_fb_valid & i_fb_prediction != i_fb_outcome): GHR <= {i_fb_ghistory[GHR_BITS-2:0], i_fb_outcome}.
  - Else i_req_valid: GHR <= {GHR[GHR_BITS-2:0], o_req_prediction}.
  - Else hold.
  - A mispredict in the same cycle as a request drops the request's speculative shift.
- Read/write to the same entry in one cycle: the prediction sees the pre-update value; the write is visible next cycle.
- Stats, RUN only:
  - o_stat_branches +1 per i_fb_valid.
  - o_stat_mispredicts +1 per mispredicting feedback.
  - Both saturate at all-ones and are registered.
- Outcome encoding: 1-bit, with 1=TAKEN and 0=NOT_TAKEN.

Test Plan:
- Sweep: GHR_BITS=8, LOCAL_IDX_BITS=6; pulse rst for 1 cycle -> o_ready low for exactly 256 cycles, then high. First prediction is 0, with pred_global=pred_local=0.
- Saturation: CTR_BITS=2; 3 taken feedbacks for PC 0x40 with fb_ghistory=0 -> o_req_pred_global=1 for PC 0x40 at GHR=0. A 4th taken plus 2 not-taken -> pred_global=0.
- GHR: 3 requests, all predicted 0, from GHR=0 -> GHR=0x00. Then mispredict feedback with fb_ghistory=0x05, outcome=1, in the same cycle as i_req_valid -> GHR=0x0B next cycle.
- Chooser: 4 feedbacks with global=0, local=1, outcome=1 at the same index -> chooser saturates at 3, and o_req_prediction follows local.
- Stats: STAT_WIDTH=4; 20 mispredicting feedbacks -> o_stat_branches=o_stat_mispredicts=15 (saturated).
- Reset mid-run: assert rst after training -> stats=0, o_ready=0, and trained entries read weak values once the sweep completes.

Source files
------------

// File: rtl/branch_predictor_tournament_p.sv
// ============================================================================
// Module   : branch_predictor_tournament_p
// Brief    : Tournament predictor (gshare + local + chooser) with an init sweep,
//            global-history repair on mispredict, and saturating statistics.
// Revision : 1.0
// ============================================================================
`default_nettype none

module branch_predictor_tournament_p #(
    parameter int ADDR_WIDTH     = 32,
    parameter int PC_SHIFT       = 2,
    parameter int GHR_BITS       = 8,
    parameter int LOCAL_IDX_BITS = 6,
    parameter int CTR_BITS       = 2,
    parameter int CHOOSER_BITS   = 2,
    parameter int STAT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_ready,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_pc,
    output logic                  o_req_prediction,
    output logic                  o_req_pred_global,
    output logic                  o_req_pred_local,
    output logic [GHR_BITS-1:0]   o_req_ghistory,
    input  logic                  i_fb_valid,
    input  logic [ADDR_WIDTH-1:0] i_fb_pc,
    input  logic [GHR_BITS-1:0]   i_fb_ghistory,
    input  logic                  i_fb_prediction,
    input  logic                  i_fb_pred_global,
    input  logic                  i_fb_pred_local,
    input  logic                  i_fb_outcome,
    output logic [STAT_WIDTH-1:0] o_stat_branches,
    output logic [STAT_WIDTH-1:0] o_stat_mispredicts
);

    localparam int c_SWEEP_BITS = (GHR_BITS > LOCAL_IDX_BITS) ? GHR_BITS : LOCAL_IDX_BITS;
    localparam int c_G_ENTRIES  = 1 << GHR_BITS;
    localparam int c_L_ENTRIES  = 1 << LOCAL_IDX_BITS;

    localparam logic [CTR_BITS-1:0]     c_CTR_WEAK   = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0]     c_CTR_ONE    = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [CHOOSER_BITS-1:0] c_CHS_WEAK   = {1'b0, {(CHOOSER_BITS-1){1'b1}}};
    localparam logic [CHOOSER_BITS-1:0] c_CHS_ONE    = {{(CHOOSER_BITS-1){1'b0}}, 1'b1};
    localparam logic [c_SWEEP_BITS-1:0] c_SWEEP_ONE  = {{(c_SWEEP_BITS-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0]   c_STAT_ONE   = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  r_state_q;
    logic                    r_ready_q;
    logic [c_SWEEP_BITS-1:0] r_sweep_q;
    logic [GHR_BITS-1:0]     r_ghr_q;
    logic [STAT_WIDTH-1:0]   r_stat_br_q;
    logic [STAT_WIDTH-1:0]   r_stat_mis_q;

    logic [CTR_BITS-1:0]     r_gshare_q  [c_G_ENTRIES];
    logic [CTR_BITS-1:0]     r_local_q   [c_L_ENTRIES];
    logic [CHOOSER_BITS-1:0] r_chooser_q [c_G_ENTRIES];

    function automatic logic [CTR_BITS-1:0] f_ctr_step(input logic [CTR_BITS-1:0] c,
                                                       input logic up);
        if (up) return (c == '1) ? c : c + c_CTR_ONE;
        else    return (c == '0) ? c : c - c_CTR_ONE;
    endfunction

    function automatic logic [CHOOSER_BITS-1:0] f_chs_step(input logic [CHOOSER_BITS-1:0] c,
                                                           input logic up);
        if (up) return (c == '1) ? c : c + c_CHS_ONE;
        else    return (c == '0) ? c : c - c_CHS_ONE;
    endfunction

    // Request path: pure table reads, so a same-cycle write is not yet visible.
    logic [GHR_BITS-1:0]       w_req_gidx;
    logic [LOCAL_IDX_BITS-1:0] w_req_lidx;
    logic [CTR_BITS-1:0]       w_req_gctr;
    logic [CTR_BITS-1:0]       w_req_lctr;
    logic [CHOOSER_BITS-1:0]   w_req_chs;
    logic                      w_pred_g;
    logic                      w_pred_l;
    logic                      w_pred;

    assign w_req_gidx = i_req_pc[PC_SHIFT +: GHR_BITS] ^ r_ghr_q;
    assign w_req_lidx = i_req_pc[PC_SHIFT +: LOCAL_IDX_BITS];
    assign w_req_gctr = r_gshare_q[w_req_gidx];
    assign w_req_lctr = r_local_q[w_req_lidx];
    assign w_req_chs  = r_chooser_q[w_req_gidx];
    assign w_pred_g   = w_req_gctr[CTR_BITS-1];
    assign w_pred_l   = w_req_lctr[CTR_BITS-1];
    assign w_pred     = w_req_chs[CHOOSER_BITS-1] ? w_pred_l : w_pred_g;

    assign o_ready            = r_ready_q;
    assign o_req_prediction   = r_ready_q & w_pred;
    assign o_req_pred_global  = r_ready_q & w_pred_g;
    assign o_req_pred_local   = r_ready_q & w_pred_l;
    assign o_req_ghistory     = r_ready_q ? r_ghr_q : '0;
    assign o_stat_branches    = r_stat_br_q;
    assign o_stat_mispredicts = r_stat_mis_q;

    // Feedback path
    logic [GHR_BITS-1:0]       w_fb_gidx;
    logic [LOCAL_IDX_BITS-1:0] w_fb_lidx;
    logic                      w_fb_mispredict;
    logic                      w_unused_pc;

    assign w_fb_gidx       = i_fb_pc[PC_SHIFT +: GHR_BITS] ^ i_fb_ghistory;
    assign w_fb_lidx       = i_fb_pc[PC_SHIFT +: LOCAL_IDX_BITS];
    assign w_fb_mispredict = i_fb_valid & (i_fb_prediction != i_fb_outcome);
    assign w_unused_pc     = ^{i_req_pc, i_fb_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_INIT;
            r_ready_q    <= 1'b0;
            r_sweep_q    <= '0;
            r_ghr_q      <= '0;
            r_stat_br_q  <= '0;
            r_stat_mis_q <= '0;
        end else begin
            case (r_state_q)
                ST_INIT: begin
                    r_sweep_q <= r_sweep_q + c_SWEEP_ONE;
                    if (r_sweep_q == '1) begin
                        r_state_q <= ST_RUN;
                        r_ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // A mispredict rebuilds history from the snapshot and
                    // discards this cycle's speculative shift.
                    if (w_fb_mispredict)
                        r_ghr_q <= {i_fb_ghistory[GHR_BITS-2:0], i_fb_outcome};
                    else if (i_req_valid)
                        r_ghr_q <= {r_ghr_q[GHR_BITS-2:0], w_pred};
                    if (i_fb_valid && (r_stat_br_q != '1))
                        r_stat_br_q <= r_stat_br_q + c_STAT_ONE;
                    if (w_fb_mispredict && (r_stat_mis_q != '1))
                        r_stat_mis_q <= r_stat_mis_q + c_STAT_ONE;
                end
                default: begin
                    r_state_q <= ST_INIT;
                    r_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state_q == ST_INIT) begin
                r_gshare_q[r_sweep_q[GHR_BITS-1:0]]        <= c_CTR_WEAK;
                r_local_q[r_sweep_q[LOCAL_IDX_BITS-1:0]]   <= c_CTR_WEAK;
                r_chooser_q[r_sweep_q[GHR_BITS-1:0]]       <= c_CHS_WEAK;
            end else if (i_fb_valid) begin
                r_gshare_q[w_fb_gidx] <= f_ctr_step(r_gshare_q[w_fb_gidx], i_fb_outcome);
                r_local_q[w_fb_lidx]  <= f_ctr_step(r_local_q[w_fb_lidx], i_fb_outcome);
                if (i_fb_pred_global != i_fb_pred_local)
                    r_chooser_q[w_fb_gidx] <= f_chs_step(r_chooser_q[w_fb_gidx],
                                                         i_fb_pred_global != i_fb_outcome);
            end
        end
    end

endmodule

`default_nettype wire
